// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags and an iterative shift-add multiplier
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output logic             busy
);
    typedef enum logic {IDLE, MUL} state_t;
    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     cnt;
    logic [SHW-1:0]     sh;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     dif;
    logic [WIDTH:0]     shl_x;
    logic [WIDTH:0]     shr_x;
    logic [WIDTH:0]     sra_x;
    logic [WIDTH-1:0]   res;
    logic               c_f;
    logic               v_f;
    logic               accept;

    assign in_ready = rst_n && state == IDLE && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign acc_nxt  = acc + (mplier[0] ? mcand : '0);

    // single-cycle result and carry/overflow for every non-multiply opcode
    always_comb begin
        sh    = input_b[SHW-1:0];
        sum   = {1'b0, input_a} + {1'b0, input_b};
        dif   = {1'b0, input_a} - {1'b0, input_b};
        shl_x = {1'b0, input_a} << sh;
        shr_x = {input_a, 1'b0} >> sh;
        sra_x = $signed({input_a, 1'b0}) >>> sh;
        res   = '0;
        c_f   = 1'b0;
        v_f   = 1'b0;
        case (op)
            4'd0: begin
                res = sum[WIDTH-1:0];
                c_f = sum[WIDTH];
                v_f = (input_a[WIDTH-1] == input_b[WIDTH-1]) && (sum[WIDTH-1] != input_a[WIDTH-1]);
            end
            4'd1: begin
                res = dif[WIDTH-1:0];
                c_f = dif[WIDTH];
                v_f = (input_a[WIDTH-1] != input_b[WIDTH-1]) && (dif[WIDTH-1] != input_a[WIDTH-1]);
            end
            4'd2: res = input_a & input_b;
            4'd3: res = input_a | input_b;
            4'd4: res = input_a ^ input_b;
            4'd5: begin
                res = shl_x[WIDTH-1:0];
                c_f = shl_x[WIDTH];
            end
            4'd6: begin
                res = shr_x[WIDTH:1];
                c_f = shr_x[0];
            end
            4'd7: begin
                res = sra_x[WIDTH:1];
                c_f = sra_x[0];
            end
            4'd8: res = {{(WIDTH-1){1'b0}}, $signed(input_a) < $signed(input_b)};
            default: res = '0;
        endcase
    end

    // control FSM, output register and multiplier datapath; the accept edge performs multiplier bit 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out       <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            if (out_ready) out_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (op == 4'd9) begin
                        acc    <= input_b[0] ? {{WIDTH{1'b0}}, input_a} : '0;
                        mcand  <= {{(WIDTH-1){1'b0}}, input_a, 1'b0};
                        mplier <= input_b >> 1;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= MUL;
                    end else begin
                        out       <= res;
                        flags     <= {res[WIDTH-1], res == '0, c_f, v_f};
                        out_valid <= 1'b1;
                    end
                end
                MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == SHW'(WIDTH - 2)) begin
                        out       <= acc_nxt[WIDTH-1:0];
                        flags     <= {acc_nxt[WIDTH-1], acc_nxt[WIDTH-1:0] == '0, |acc_nxt[2*WIDTH-1:WIDTH], 1'b0};
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = '0;
    logic [15:0] input_a = '0;
    logic [15:0] input_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out;
    logic [3:0]  flags;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    bit          m_valid = 1'b0;
    bit          m_busy = 1'b0;
    int          m_cnt = 0;
    logic [15:0] m_out = '0;
    logic [3:0]  m_flags = '0;
    logic [15:0] p_out = '0;
    logic [3:0]  p_flags = '0;

    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .input_a(input_a), .input_b(input_b), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .flags(flags), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void ref_alu(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] r, output logic [3:0] f);
        int sa, sb, ss, sh;
        longint p;
        logic c, v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        sh = int'(b[3:0]);
        c = 1'b0;
        v = 1'b0;
        r = '0;
        p = 0;
        case (o)
            4'd0: begin p = longint'(a) + longint'(b); r = p[15:0]; c = p > 65535; ss = sa + sb; v = ss > 32767 || ss < -32768; end
            4'd1: begin r = a - b; c = a < b; ss = sa - sb; v = ss > 32767 || ss < -32768; end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin p = longint'(a) << sh; r = p[15:0]; c = sh != 0 && p[16]; end
            4'd6: begin r = a >> sh; c = sh != 0 && a[sh-1]; end
            4'd7: begin ss = sa >>> sh; r = ss[15:0]; c = sh != 0 && a[sh-1]; end
            4'd8: r = (sa < sb) ? 16'd1 : 16'd0;
            4'd9: begin p = longint'(a) * longint'(b); r = p[15:0]; c = (p >> 16) != 0; end
            default: r = '0;
        endcase
        f = {r[15], r == 16'd0, c, v};
    endfunction

    // reference model: advances once per rising edge from the inputs present at that edge
    always @(posedge clk) begin
        logic [15:0] r;
        logic [3:0]  f;
        bit          acc;
        if (!rst_n) begin
            m_valid = 0; m_busy = 0; m_cnt = 0; m_out = '0; m_flags = '0;
        end else begin
            acc = in_valid && !m_busy && (!m_valid || out_ready);
            if (m_valid && out_ready) m_valid = 0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 0; m_valid = 1; m_out = p_out; m_flags = p_flags;
                end
            end else if (acc) begin
                ref_alu(op, input_a, input_b, r, f);
                if (op == 4'd9) begin
                    m_busy = 1; m_cnt = 15; p_out = r; p_flags = f;
                end else begin
                    m_valid = 1; m_out = r; m_flags = f;
                end
            end
        end
    end

    // scoreboard compare on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("sb_in_ready", in_ready, rst_n && !m_busy && (!m_valid || out_ready));
            check("sb_out_valid", out_valid, m_valid);
            check("sb_busy", busy, m_busy);
            check("sb_out", out, m_out);
            check("sb_flags", flags, m_flags);
        end
    end

    task automatic send(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        bit r;
        int n;
        in_valid = 1'b1; op = o; input_a = a; input_b = b;
        n = 0;
        r = 1'b0;
        while (!r && n < 50) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!r) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic txn(input string name, input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eo, input logic [3:0] ef, input int elat);
        int n;
        send(o, a, b);
        n = 1;
        while (!out_valid && n < 40) begin
            if (elat > 1) check({name, "_busy_rdy"}, {busy, in_ready}, 2'b10);
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_latency"}, n, elat);
        check({name, "_out"}, out, eo);
        check({name, "_flags"}, flags, ef);
        if (elat > 1) check({name, "_busy_end"}, busy, 0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_out", out, 0);
        check("reset_in_ready", in_ready, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        txn("add", 4'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1);
        txn("sub", 4'd1, 16'h0001, 16'h0002, 16'hFFFF, 4'b1010, 1);
        txn("mul_ovf", 4'd9, 16'h0100, 16'h0100, 16'h0000, 4'b0110, 16);
        txn("mul", 4'd9, 16'h00FF, 16'h0003, 16'h02FD, 4'b0000, 16);
        txn("sra", 4'd7, 16'h8001, 16'h0001, 16'hC000, 4'b1010, 1);
        txn("shl0", 4'd5, 16'h1234, 16'h0010, 16'h1234, 4'b0000, 1);
        txn("shr15", 4'd6, 16'h8000, 16'h000F, 16'h0001, 4'b0000, 1);
        txn("slt", 4'd8, 16'hFFFF, 16'h0001, 16'h0001, 4'b0000, 1);
        txn("illegal", 4'd12, 16'h1234, 16'h5678, 16'h0000, 4'b0100, 1);

        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(4'd0, 16'd1, 16'd1);
        in_valid = 1'b1; op = 4'd0; input_a = 16'd3; input_b = 16'd4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_out", out, 16'd2);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_up", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_second_valid", out_valid, 1);
        check("bp_second_out", out, 16'd7);
        @(posedge clk);
        #1;
        check("bp_drained", out_valid, 0);

        send(4'd9, 16'h00FF, 16'h0003);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mul_valid", out_valid, 0);
        check("rst_mul_busy", busy, 0);
        check("rst_mul_out", out, 0);
        check("rst_mul_in_ready", in_ready, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("rst_no_stale", out_valid, 0);
        end
        txn("add_after_rst", 4'd0, 16'd2, 16'd3, 16'd5, 4'b0000, 1);

        for (int i = 0; i < 1500; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            op        = 4'($urandom_range(0, 15));
            input_a   = ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom);
            input_b   = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 17)) : 16'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            rst_n     = $urandom_range(0, 199) != 0;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
